xadc_sync_demod: RTL
====================

// Module: xadc_sync_demod
// PURPOSE
//  Multi-channel synchronous demodulator fed by the XADC dynamic reconfiguration port (DRP).
//  - Per frame: reads one switch-reference channel, then NUM_FEED feedhorn channels.
//  - Per feed channel: accumulates samples into an on bank or an off bank, chosen by switch phase.
//  - After NUM_FRAMES frames: emits per-channel sums/counts over a valid/ready stream to downstream math.
//  Sits between xadc_wiz_0 (DRP side) and the radiometer back-end. Streaming: no sample arrays.
// PARAMETERS
//  NUM_FEED    4       feed channels, 1..15, on VAUX(FEED_BASE..FEED_BASE+NUM_FEED-1)
//  NUM_FRAMES  256     frames per integration, 2..65536
//  SW_ADDR     7'h10   DRP address of the switch channel (VAUX0)
//  FEED_BASE   7'h11   DRP address of the first feed channel (VAUX1)
//  THRESH_HI   12'd2048  switch code >= this sets phase ON
//  THRESH_LO   12'd1536  switch code <  this clears phase ON; must be <= THRESH_HI
//  DRDY_TO     64      cycles to wait for drdy after den before timeout
// PORTS
//  clk          in   1   DRP/system clock (same clock as xadc dclk_in)
//  clr_n        in   1   asynchronous active-low reset
//  enable       in   1   1 = run; 0 = finish current frame, then idle
//  continuous   in   1   1 = restart integration after emit; 0 = single integration, then idle
//  eoc          in   1   XADC end-of-conversion pulse
//  drdy         in   1   DRP data ready
//  do_in        in   16  DRP read data; code = do_in[15:4]
//  daddr        out  7   DRP address
//  den          out  1   DRP enable, 1-cycle pulse
//  res_valid    out  1   result beat valid
//  res_ready    in   1   downstream accepts beat
//  res_chan     out  4   feed channel index of beat
//  res_on_sum   out  12+clog2(NUM_FRAMES)  sum of on-phase codes
//  res_off_sum  out  12+clog2(NUM_FRAMES)  sum of off-phase codes
//  res_on_cnt   out  clog2(NUM_FRAMES+1)   on-phase sample count
//  res_off_cnt  out  clog2(NUM_FRAMES+1)   off-phase sample count
//  res_degen    out  1   beat has on_cnt==0 or off_cnt==0
//  overrun      out  1   sticky: eoc seen while a DRP read is outstanding
//  drdy_err     out  1   sticky: drdy timeout
// BEHAVIOUR
//  Reset: all outputs 0; daddr=SW_ADDR; sw_on=0; all accumulators, counters and state cleared.
//  States:
//   IDLE -> WAIT_EOC when enable=1.
//   WAIT_EOC: on eoc, next cycle drive den=1 for 1 cycle with daddr=slot address -> DRP_RD.
//    Slot 0 = SW_ADDR; slot k>=1 = FEED_BASE+k-1.
//   DRP_RD: on drdy, latch do_in[15:4] -> ACCUM (1 cycle).
//    If no drdy within DRDY_TO cycles: set drdy_err, drop slot, advance as if it had been read.
//   ACCUM, slot 0: update sw_on from the code by hysteresis.
//    Code between thresholds: sw_on held.
//   ACCUM, slot k>=1: add code to on or off bank of channel k-1 per sw_on; increment matching count.
//   ACCUM exit: last slot -> frame++; else slot++.
//    frame==NUM_FRAMES -> EMIT; !enable at frame end -> IDLE (banks kept); else WAIT_EOC.
//   EMIT: beats chan 0..NUM_FEED-1; beat transfers when res_valid&res_ready.
//    Payload stable while valid && !ready.
//    After last beat: clear banks and frame; continuous&&enable -> WAIT_EOC, else IDLE.
//  eoc in DRP_RD/ACCUM: ignored; sets overrun. eoc in EMIT/IDLE: ignored, no flag.
//  Sums cannot overflow at declared widths; counts saturate never (on_cnt+off_cnt==NUM_FRAMES).
//  Latency: eoc -> den 1 cycle; drdy -> bank update 1 cycle; last ACCUM -> res_valid next cycle.
//  sw_on persists across frames and integrations; reset only by clr_n.
//  clr_n mid-operation: immediate clear; no partial beat emitted.
//  Sticky flags clear only on clr_n.
// STRUCTURE
//  Package adc_demod_pkg:
//   - state encoding
//   - XADC VAUX address constants
//   - width helper functions (sum and count widths)
//  Sub-module xadc_drp_reader: den pulse, drdy wait, timeout, code latch.
//   Interface: req/addr in, done/code/timeout out.
//  Banks: register arrays indexed by channel; single adder shared across slots.
// TESTING
//  1 NUM_FEED=2, NUM_FRAMES=4, switch 4000/0 alternating, feeds 100/200 constant
//    -> ch0 on_sum=200 on_cnt=2 off_sum=200 off_cnt=2; ch1 on_sum=400 off_sum=400.
//  2 switch codes 4000,1800,1800,1000 (hysteresis band)
//    -> on_cnt=3, off_cnt=1 per channel.
//  3 switch held 4000
//    -> res_degen=1 on every beat, off_cnt=0.
//  4 res_ready low 10 cycles in EMIT
//    -> payload stable; no eoc acted on; beats emitted in order 0..NUM_FEED-1.
//  5 drdy withheld on slot 1
//    -> drdy_err set after DRDY_TO cycles; count for that channel one short; FSM continues.
//  6 clr_n low mid-DRP_RD; eoc during DRP_RD
//    -> all outputs 0 immediately after reset; overrun=1 after the eoc case.

Source files
------------

// File: rtl/adc_demod_pkg.sv
// Shared types, XADC addresses and width helpers for the synchronous demodulator.
package adc_demod_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_EOC,
    S_DRP_RD,
    S_ACCUM,
    S_EMIT
  } state_t;

  localparam logic [6:0] VAUX0_ADDR = 7'h10;
  localparam logic [6:0] VAUX1_ADDR = 7'h11;

  function automatic int sum_w(input int frames);
    return 12 + $clog2(frames);
  endfunction

  function automatic int cnt_w(input int frames);
    return $clog2(frames + 1);
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xadc_drp_reader.sv
// One DRP read per req: 1-cycle den pulse, waits for drdy or DRDY_TO cycles.
// done/timeout are combinational strobes in the cycle drdy arrives or the wait expires.
module xadc_drp_reader #(
  parameter int         DRDY_TO  = 64,
  parameter logic [6:0] RST_ADDR = 7'h10
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        req,
  input  logic [6:0]  addr,
  input  logic        drdy,
  input  logic [15:0] do_in,
  output logic [6:0]  daddr,
  output logic        den,
  output logic        done,
  output logic        timeout,
  output logic [11:0] code
);

  localparam int TW = $clog2(DRDY_TO + 1);

  logic          busy;
  logic [TW-1:0] timer;
  logic          unused_lsb;

  assign unused_lsb = ^do_in[3:0];
  assign done       = busy && drdy;
  assign timeout    = busy && !drdy && (timer == TW'(DRDY_TO - 1));

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      daddr <= RST_ADDR;
      den   <= 1'b0;
      busy  <= 1'b0;
      timer <= '0;
      code  <= '0;
    end else begin
      den <= req;
      if (req) begin
        daddr <= addr;
        busy  <= 1'b1;
        timer <= '0;
      end else if (busy) begin
        if (drdy) begin
          code <= do_in[15:4];
          busy <= 1'b0;
        end else if (timeout) begin
          busy <= 1'b0;
        end else begin
          timer <= timer + TW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/xadc_sync_demod.sv
// Switch-phase synchronous demodulator over XADC DRP; banks sum per feed, emitted as one beat per channel.
// eoc->den 1 cycle, drdy->bank 1 cycle; EMIT holds payload while res_ready is low and ignores eoc.
module xadc_sync_demod
  import adc_demod_pkg::*;
#(
  parameter int          NUM_FEED   = 4,
  parameter int          NUM_FRAMES = 256,
  parameter logic [6:0]  SW_ADDR    = VAUX0_ADDR,
  parameter logic [6:0]  FEED_BASE  = VAUX1_ADDR,
  parameter logic [11:0] THRESH_HI  = 12'd2048,
  parameter logic [11:0] THRESH_LO  = 12'd1536,
  parameter int          DRDY_TO    = 64
) (
  input  logic                            clk,
  input  logic                            clr_n,
  input  logic                            enable,
  input  logic                            continuous,
  input  logic                            eoc,
  input  logic                            drdy,
  input  logic [15:0]                     do_in,
  output logic [6:0]                      daddr,
  output logic                            den,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [3:0]                      res_chan,
  output logic [sum_w(NUM_FRAMES)-1:0]    res_on_sum,
  output logic [sum_w(NUM_FRAMES)-1:0]    res_off_sum,
  output logic [cnt_w(NUM_FRAMES)-1:0]    res_on_cnt,
  output logic [cnt_w(NUM_FRAMES)-1:0]    res_off_cnt,
  output logic                            res_degen,
  output logic                            overrun,
  output logic                            drdy_err
);

  localparam int SUM_W = sum_w(NUM_FRAMES);
  localparam int CNT_W = cnt_w(NUM_FRAMES);
  localparam int CH_W  = idx_w(NUM_FEED);
  localparam logic [3:0]       LAST_SLOT  = 4'(NUM_FEED);
  localparam logic [3:0]       LAST_CH    = 4'(NUM_FEED - 1);
  localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(NUM_FRAMES - 1);

  state_t           state;
  logic [3:0]       slot;
  logic [3:0]       emit_ch;
  logic [CNT_W-1:0] frame;
  logic             sw_on;
  logic             drop;

  logic [SUM_W-1:0] on_sum  [NUM_FEED];
  logic [SUM_W-1:0] off_sum [NUM_FEED];
  logic [CNT_W-1:0] on_cnt  [NUM_FEED];
  logic [CNT_W-1:0] off_cnt [NUM_FEED];

  logic             rd_req, rd_done, rd_timeout;
  logic [11:0]      code;
  logic [6:0]       slot_addr;
  logic [CH_W-1:0]  ch, out_ch;
  logic [SUM_W-1:0] acc_sum;

  assign rd_req    = (state == S_WAIT_EOC) && eoc;
  assign slot_addr = (slot == 4'd0) ? SW_ADDR : FEED_BASE + 7'(slot) - 7'd1;
  assign ch        = CH_W'(slot - 4'd1);
  // One adder serves every feed slot; the phase picks which bank it reads.
  assign acc_sum   = (sw_on ? on_sum[ch] : off_sum[ch]) + SUM_W'(code);

  assign out_ch      = CH_W'(emit_ch);
  assign res_chan    = emit_ch;
  assign res_on_sum  = on_sum[out_ch];
  assign res_off_sum = off_sum[out_ch];
  assign res_on_cnt  = on_cnt[out_ch];
  assign res_off_cnt = off_cnt[out_ch];
  assign res_degen   = res_valid && (on_cnt[out_ch] == '0 || off_cnt[out_ch] == '0);

  xadc_drp_reader #(.DRDY_TO(DRDY_TO), .RST_ADDR(SW_ADDR)) u_rd (
    .clk     (clk),
    .clr_n   (clr_n),
    .req     (rd_req),
    .addr    (slot_addr),
    .drdy    (drdy),
    .do_in   (do_in),
    .daddr   (daddr),
    .den     (den),
    .done    (rd_done),
    .timeout (rd_timeout),
    .code    (code)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state     <= S_IDLE;
      slot      <= '0;
      emit_ch   <= '0;
      frame     <= '0;
      sw_on     <= 1'b0;
      drop      <= 1'b0;
      res_valid <= 1'b0;
      overrun   <= 1'b0;
      drdy_err  <= 1'b0;
      for (int i = 0; i < NUM_FEED; i++) begin
        on_sum[i]  <= '0;
        off_sum[i] <= '0;
        on_cnt[i]  <= '0;
        off_cnt[i] <= '0;
      end
    end else begin
      if (eoc && (state == S_DRP_RD || state == S_ACCUM)) overrun <= 1'b1;
      case (state)
        S_IDLE:     if (enable) state <= S_WAIT_EOC;
        S_WAIT_EOC: if (eoc) state <= S_DRP_RD;
        S_DRP_RD: begin
          if (rd_done) begin
            drop  <= 1'b0;
            state <= S_ACCUM;
          end else if (rd_timeout) begin
            drop     <= 1'b1;
            drdy_err <= 1'b1;
            state    <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (!drop) begin
            if (slot == 4'd0) begin
              if (code >= THRESH_HI)     sw_on <= 1'b1;
              else if (code < THRESH_LO) sw_on <= 1'b0;
            end else if (sw_on) begin
              on_sum[ch] <= acc_sum;
              on_cnt[ch] <= on_cnt[ch] + CNT_W'(1);
            end else begin
              off_sum[ch] <= acc_sum;
              off_cnt[ch] <= off_cnt[ch] + CNT_W'(1);
            end
          end
          if (slot == LAST_SLOT) begin
            slot  <= '0;
            frame <= frame + CNT_W'(1);
            if (frame == LAST_FRAME) begin
              state     <= S_EMIT;
              res_valid <= 1'b1;
              emit_ch   <= '0;
            end else begin
              state <= enable ? S_WAIT_EOC : S_IDLE;
            end
          end else begin
            slot  <= slot + 4'd1;
            state <= S_WAIT_EOC;
          end
        end
        S_EMIT: begin
          if (res_valid && res_ready) begin
            if (emit_ch == LAST_CH) begin
              res_valid <= 1'b0;
              emit_ch   <= '0;
              frame     <= '0;
              for (int i = 0; i < NUM_FEED; i++) begin
                on_sum[i]  <= '0;
                off_sum[i] <= '0;
                on_cnt[i]  <= '0;
                off_cnt[i] <= '0;
              end
              state <= (continuous && enable) ? S_WAIT_EOC : S_IDLE;
            end else begin
              emit_ch <= emit_ch + 4'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
